// File: rtl/mux4_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mux4_rr_arbiter
// Description : Round-robin arbiter sharing one 4:1 active-high-enable mux
//               among four requesters. Drives the mux select/enable from
//               registered state, returns a one-hot grant, bounds each
//               contended tenure to HOLD_MAX cycles and inserts a one-cycle
//               disabled gap between owners.
// Revision    : 1.0 - initial release
// ============================================================================
module mux4_rr_arbiter #(
    parameter int HOLD_MAX = 8,
    parameter int CW       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic [1:0] S,
    output logic       E,
    output logic       busy
);

    // State encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    // Final counter value of a tenure; reaching it triggers rotation when
    // somebody else is waiting, otherwise the counter wraps.
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_MAX - 1);

    logic [1:0]    state;
    logic [CW-1:0] hold_cnt;
    logic [1:0]    last;

    logic [1:0]    winner;
    logic          any_req;
    logic          owner_req;
    logic          other_req;

    // Round-robin pick: first requesting index scanning upward from last+1
    always_comb begin
        logic       found;
        logic [1:0] idx;
        winner = last;
        found  = 1'b0;
        idx    = last;
        for (int k = 1; k <= 4; k++) begin
            idx = last + 2'(k);
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    // Request summaries relative to the current owner (grant is one-hot in GRANT)
    always_comb begin
        any_req   = |req;
        owner_req = |(req & grant);
        other_req = |(req & ~grant);
    end

    // Arbitration state machine; every output is a register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            grant    <= 4'b0000;
            S        <= 2'b00;
            E        <= 1'b0;
            busy     <= 1'b0;
            hold_cnt <= '0;
            last     <= 2'd3;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        state    <= ST_GRANT;
                        grant    <= 4'b0001 << winner;
                        S        <= winner;
                        E        <= 1'b1;
                        busy     <= 1'b1;
                        hold_cnt <= '0;
                        last     <= winner;
                    end
                end
                ST_GRANT: begin
                    if (!owner_req || (hold_cnt == HOLD_LAST && other_req)) begin
                        // Release: owner dropped or forced rotation
                        state <= ST_GAP;
                        grant <= 4'b0000;
                        E     <= 1'b0;
                    end else if (hold_cnt == HOLD_LAST) begin
                        // Uncontested owner keeps the mux; restart the tenure count
                        hold_cnt <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + CW'(1);
                    end
                end
                ST_GAP: begin
                    if (any_req) begin
                        state    <= ST_GRANT;
                        grant    <= 4'b0001 << winner;
                        S        <= winner;
                        E        <= 1'b1;
                        hold_cnt <= '0;
                        last     <= winner;
                    end else begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    grant <= 4'b0000;
                    E     <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mux4_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux4_rr_arbiter
// Description : Directed self-checking bench for mux4_rr_arbiter. Two
//               instances: HOLD_MAX=8 and HOLD_MAX=4. Observed word is
//               {busy, E, S[1:0], grant[3:0]}.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux4_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] req8 = 4'b0000;
    logic [3:0] req4 = 4'b0000;

    logic [3:0] grant8, grant4;
    logic [1:0] s8, s4;
    logic       e8, e4, busy8, busy4;

    int tests = 0;
    int fails = 0;

    mux4_rr_arbiter #(.HOLD_MAX(8), .CW(8)) u_dut8 (
        .clk(clk), .rst(rst), .req(req8),
        .grant(grant8), .S(s8), .E(e8), .busy(busy8)
    );

    mux4_rr_arbiter #(.HOLD_MAX(4), .CW(8)) u_dut4 (
        .clk(clk), .rst(rst), .req(req4),
        .grant(grant4), .S(s4), .E(e4), .busy(busy4)
    );

    always #5 clk = ~clk;

    logic [7:0] obs8, obs4;
    assign obs8 = {busy8, e8, s8, grant8};
    assign obs4 = {busy4, e4, s4, grant4};

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle at the falling edge for sampling
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        // Reset state
        #1 rst = 1'b1;
        #1;
        chk("reset8", obs8, 8'h00);
        chk("reset4", obs4, 8'h00);
        @(negedge clk);
        rst = 1'b0;

        // Idle with no requests
        for (int i = 0; i < 5; i++) begin
            step();
            chk("idle", obs8, 8'h00);
        end

        // Single requester 2 for three cycles, then GAP, then IDLE
        req8 = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("single2", obs8, 8'hE4);
        end
        req8 = 4'b0000;
        step();
        chk("single2_gap", obs8, 8'hA0);
        step();
        chk("single2_idle", obs8, 8'h20);

        // Fresh reset, then all four requesting: rotation 0,1,2,3,0
        rst = 1'b1;
        #1;
        chk("reset_again", obs8, 8'h00);
        rst = 1'b0;
        req8 = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            logic [1:0] o;
            o = 2'(n);
            for (int c = 0; c < 8; c++) begin
                step();
                chk("rot_grant", obs8, {2'b11, o, 4'b0001 << o});
            end
            step();
            chk("rot_gap", obs8, {2'b10, o, 4'b0000});
        end
        req8 = 4'b0000;
        step();
        chk("rot_idle", obs8, 8'h00);

        // Uncontested requester 1 keeps the mux across counter wraps
        req8 = 4'b0010;
        for (int i = 0; i < 30; i++) begin
            step();
            chk("uncontested1", obs8, 8'hD2);
        end
        req8 = 4'b0000;
        step();
        chk("unc_gap", obs8, 8'h90);
        step();
        chk("unc_idle", obs8, 8'h10);

        // HOLD_MAX=4 instance: owner 0, then req becomes 1010 at counter=3
        req4 = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("h4_own0", obs4, 8'hC1);
        end
        req4 = 4'b1010;
        step();
        chk("h4_gap0", obs4, 8'h80);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("h4_own1", obs4, 8'hD2);
        end
        step();
        chk("h4_gap1", obs4, 8'h90);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("h4_own3", obs4, 8'hF8);
        end
        step();
        chk("h4_gap3", obs4, 8'hB0);
        step();
        chk("h4_back1", obs4, 8'hD2);
        req4 = 4'b0000;
        step();
        chk("h4_gap_end", obs4, 8'h90);
        step();
        chk("h4_idle", obs4, 8'h10);

        // Asynchronous reset in the middle of owner 2's tenure
        req8 = 4'b0100;
        step();
        chk("pre_rst_own2", obs8, 8'hE4);
        step();
        chk("pre_rst_own2b", obs8, 8'hE4);
        rst = 1'b1;
        #1;
        chk("async_rst", obs8, 8'h00);
        req8 = 4'b1100;
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("post_rst_win2", obs8, 8'hE4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter that shares one 4:1 active-high-enable mux among four requesters.
- Drives the mux select (S) and enable (E) from registered state, and returns a one-hot grant to each requester.
- Bounds each tenure with a hold limit so no requester starves.
- Between owners it inserts one disabled cycle (E=0), so the mux output parks at its idle-high value.

Parameters:
- HOLD_MAX, 8, maximum consecutive GRANT cycles per tenure while another requester waits; legal range 1..255.
- CW, 8, width of the hold counter; must satisfy 2^CW > HOLD_MAX.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous active-high reset.
- req  input  4  level request; req[i]=1 means requester i wants the mux.
- grant  output  4  one-hot registered grant; all zero when no owner.
- S  output  2  mux select, equal to the binary index of the current or last owner.
- E  output  1  mux enable; 1 only in GRANT.
- busy  output  1  1 in GRANT or GAP.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high. Clock port is clk, reset port is rst.
- Reset state: state=IDLE, grant=4'b0000, S=2'b00, E=0, busy=0, hold counter=0, last pointer=3 (so requester 0 wins first).
- All outputs are registered and change only on the clk rising edge or on rst assertion.
- Round-robin pick: search upward from last+1 modulo 4; the first index with req=1 wins.
  - Example: last=1, req=4'b1001 -> winner 3.
- IDLE:
  - Stay while req=0.
  - If any req bit is 1 at an edge, go to GRANT on that same edge.
  - On entry: grant=onehot(winner), S=winner, E=1, busy=1, counter=0, last=winner.
  - Latency: req sampled high at edge k -> grant/E visible after edge k.
- GRANT, evaluated at each edge:
  - req[owner]=0 -> go to GAP.
  - Else if counter==HOLD_MAX-1 and any other req bit is 1 -> go to GAP (forced rotation).
  - Else if counter==HOLD_MAX-1 and no other request -> stay; counter resets to 0 (owner keeps the mux indefinitely when uncontested).
  - Else stay; counter increments.
- GAP (exactly one cycle):
  - grant=0, E=0, busy=1, S holds the previous owner.
  - At the next edge: if any req, go to GRANT with a new winner picked from last+1. A lone original owner may regain the mux.
  - If no req, go to IDLE (busy=0).
- Tenure length: a contended owner holds E=1 for exactly HOLD_MAX cycles. With HOLD_MAX=1, owners alternate GRANT/GAP every cycle.
- Changes to non-owner req bits during GRANT have no effect until the next arbitration.
- In IDLE and GAP, S keeps its last value. The mux output is 1 regardless, because E=0.
- Reset asserted mid-GRANT or mid-GAP: outputs go to reset values immediately, without waiting for clk. Arbitration restarts with requester 0 priority after rst deasserts.
- Invariants:
  - grant is zero or one-hot.
  - E==|grant.
  - When E=1, grant==onehot(S).

Test Plan:
- Reset, then req=4'b0000 for 5 cycles -> grant=0, E=0, busy=0, S=0 throughout.
- req=4'b0100 raised before edge k, held 3 cycles then dropped -> after edge k: grant=4'b0100, S=2, E=1 for 3 cycles; then one GAP cycle (E=0, busy=1); then IDLE.
- req=4'b1111 held constant, HOLD_MAX=8 -> owners rotate 0,1,2,3,0:
  - each owner holds E=1 for 8 cycles;
  - one E=0 gap between owners;
  - period is 9 cycles per owner.
- req=4'b0010 only, held 30 cycles -> grant stays 4'b0010 with no GAP. The counter wraps at 7 without releasing.
- Owner 0 in GRANT, req changes to 4'b1010 at counter=3, HOLD_MAX=4 -> release after 4th cycle, GAP, then grant=4'b0010 (S=1). Requester 3 is served next.
- Assert rst asynchronously mid-tenure of owner 2 -> grant=0 and E=0 before the next clk edge. After release with req=4'b1100, the first grant goes to requester 2 (search from 0).
